// File: rtl/msg_schedule_ctrl.sv
// SHA-256 message schedule sequencer: loads W0..W15, then streams W0..W63
// using a 16-entry circular buffer that is overwritten in place as words expand.

module sha256_sig0 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module sha256_sig1 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module msg_schedule_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] S_word_in,
  input  logic                  S_valid_in,
  output logic                  D_ready_out,
  output logic [DATA_WIDTH-1:0] D_W_out,
  output logic [5:0]            D_t_out,
  output logic                  D_valid_out,
  input  logic                  S_ready_in,
  output logic                  D_busy_out,
  output logic                  D_done_out
);

  typedef enum logic {LOAD, STREAM} state_t;

  localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - 1);

  state_t                state, state_next;
  logic [3:0]            ld_cnt, ld_cnt_next;
  logic [5:0]            t, t_next;
  logic                  done_next;
  logic                  load_we, exp_we;
  logic [DATA_WIDTH-1:0] word_buf [16];
  logic [DATA_WIDTH-1:0] s0_out, s1_out, w_exp;
  logic [3:0]            idx_t, idx_m2, idx_m7, idx_m15;

  // 4-bit subtraction gives the mod-16 circular buffer offsets for free
  assign idx_t   = t[3:0];
  assign idx_m2  = idx_t - 4'd2;
  assign idx_m7  = idx_t - 4'd7;
  assign idx_m15 = idx_t - 4'd15;

  sha256_sig0 u_sig0 (.x(word_buf[idx_m15]), .y(s0_out));
  sha256_sig1 u_sig1 (.x(word_buf[idx_m2]),  .y(s1_out));

  assign w_exp      = s1_out + word_buf[idx_m7] + s0_out + word_buf[idx_t];
  assign D_busy_out = (ld_cnt != 4'd0) || (state == STREAM);

  always_comb begin
    state_next  = state;
    ld_cnt_next = ld_cnt;
    t_next      = t;
    done_next   = 1'b0;
    load_we     = 1'b0;
    exp_we      = 1'b0;
    D_ready_out = 1'b0;
    D_valid_out = 1'b0;
    D_W_out     = '0;
    D_t_out     = '0;
    case (state)
      LOAD: begin
        D_ready_out = 1'b1;
        if (S_valid_in) begin
          load_we     = 1'b1;
          ld_cnt_next = ld_cnt + 4'd1;
          if (ld_cnt == 4'd15) begin
            state_next = STREAM;
            t_next     = '0;
          end
        end
      end
      STREAM: begin
        D_valid_out = 1'b1;
        D_t_out     = t;
        D_W_out     = (t < 6'd16) ? word_buf[idx_t] : w_exp;
        if (S_ready_in) begin
          exp_we = (t >= 6'd16);
          if (t == T_LAST) begin
            state_next = LOAD;
            t_next     = '0;
            done_next  = 1'b1;
          end else begin
            t_next = t + 6'd1;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      ld_cnt     <= '0;
      t          <= '0;
      D_done_out <= 1'b0;
    end else begin
      state      <= state_next;
      ld_cnt     <= ld_cnt_next;
      t          <= t_next;
      D_done_out <= done_next;
    end
  end

  // W_t replaces W_(t-16), the oldest word, which it no longer needs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) word_buf[i] <= '0;
    end else if (load_we) begin
      word_buf[ld_cnt] <= S_word_in;
    end else if (exp_we) begin
      word_buf[idx_t] <= w_exp;
    end
  end

endmodule

// File: tb/tb_msg_schedule_ctrl.sv
// Scoreboard bench for msg_schedule_ctrl: a reference SHA-256 schedule model
// fills an expected queue per block; a negedge monitor checks every output.

module tb_msg_schedule_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] S_word_in;
  logic        S_valid_in;
  logic        D_ready_out;
  logic [31:0] D_W_out;
  logic [5:0]  D_t_out;
  logic        D_valid_out;
  logic        S_ready_in;
  logic        D_busy_out;
  logic        D_done_out;

  msg_schedule_ctrl #(.DATA_WIDTH(32), .NUM_ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_word_in(S_word_in), .S_valid_in(S_valid_in), .D_ready_out(D_ready_out),
    .D_W_out(D_W_out), .D_t_out(D_t_out), .D_valid_out(D_valid_out),
    .S_ready_in(S_ready_in), .D_busy_out(D_busy_out), .D_done_out(D_done_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [31:0] w;
    int          hs;
    bit          full;
    bit          has_gold;
    logic [31:0] gold;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ld_model = 0;
  int   last_hs = 0;
  bit   bp_mode = 1'b0;
  bit   seen_t0 = 1'b0;
  bit   done_pending = 1'b0;
  bit   done_full = 1'b0;
  int   done_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    S_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      S_ready_in = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h cyc=%0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [31:0] blk [16], input int hs, input bit abc);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      e.t = i; e.w = w[i]; e.hs = hs; e.full = !bp_mode;
      e.has_gold = 1'b0; e.gold = '0;
      if (abc && i == 16) begin e.has_gold = 1'b1; e.gold = 32'h61626380; end
      if (abc && i == 17) begin e.has_gold = 1'b1; e.gold = 32'h000F0000; end
      exp_q.push_back(e);
    end
  endtask

  task automatic send_block(input logic [31:0] blk [16], input bit gap, input bit abc);
    bit fire;
    int n;
    for (int i = 0; i < 16; i++) begin
      if (gap) begin
        repeat ($urandom_range(0, 2)) begin
          S_valid_in = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      S_valid_in = 1'b1;
      S_word_in  = blk[i];
      fire = 1'b0;
      n = 0;
      while (!fire && n < 1000) begin
        @(negedge clk);
        fire = D_ready_out;
        @(posedge clk);
        #1;
        n++;
      end
      if (!fire) begin
        checks++; failures++;
        $display("FAIL load_timeout word=%0d actual=no_handshake required=handshake", i);
      end
      ld_model = (ld_model + 1) % 16;
      S_valid_in = 1'b0;
    end
    last_hs = cyc;
    push_block(blk, cyc, abc);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || done_pending) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle compares all outputs against the model-side state
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("D_ready_out", D_ready_out, (exp_q.size() == 0));
      chk("D_busy_out", D_busy_out, (ld_model != 0) || (exp_q.size() != 0));
      chk("D_done_out", D_done_out, done_pending);
      if (done_pending && done_full) chk("done_latency", cyc, done_cyc);
      done_pending = 1'b0;
      if (exp_q.size() == 0) begin
        chk("D_valid_out_idle", D_valid_out, 1'b0);
      end else begin
        e = exp_q[0];
        chk("D_valid_out", D_valid_out, 1'b1);
        chk($sformatf("D_t_out t=%0d", e.t), D_t_out, e.t);
        chk($sformatf("D_W_out t=%0d", e.t), D_W_out, e.w);
        if (e.has_gold) chk($sformatf("abc_golden t=%0d", e.t), D_W_out, e.gold);
        if (e.t == 0 && !seen_t0) begin
          chk("w0_latency", cyc, e.hs);
          seen_t0 = 1'b1;
        end
        if (S_ready_in) begin
          void'(exp_q.pop_front());
          seen_t0 = 1'b0;
          if (e.t == 63) begin
            done_pending = 1'b1;
            done_full    = e.full;
            done_cyc     = e.hs + 64;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, D_valid_out, 1'b0);
    chk({tag, "_done"},  D_done_out, 1'b0);
    chk({tag, "_busy"},  D_busy_out, 1'b0);
    chk({tag, "_t"},     D_t_out, 6'd0);
    chk({tag, "_w"},     D_W_out, 32'd0);
    chk({tag, "_ready"}, D_ready_out, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] abc [16];
    logic [31:0] zero [16];
    logic [31:0] ra [16];
    logic [31:0] rb [16];

    for (int i = 0; i < 16; i++) begin
      abc[i] = '0;
      zero[i] = '0;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    rst_n = 1'b0;
    S_valid_in = 1'b0;
    S_word_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_block(abc, 1'b0, 1'b1);
    wait_drain();

    send_block(zero, 1'b0, 1'b0);
    wait_drain();

    bp_mode = 1'b1;
    send_block(abc, 1'b0, 1'b1);
    wait_drain();
    bp_mode = 1'b0;

    // second block is offered while the first streams
    for (int i = 0; i < 16; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
    end
    send_block(ra, 1'b0, 1'b0);
    send_block(rb, 1'b0, 1'b0);
    wait_drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 16; i++) ra[i] = $urandom;
    send_block(ra, 1'b1, 1'b0);
    wait_drain();
    bp_mode = 1'b0;

    send_block(abc, 1'b0, 1'b1);
    while (cyc < last_hs + 30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    done_pending = 1'b0;
    seen_t0 = 1'b0;
    ld_model = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_block(abc, 1'b0, 1'b1);
    wait_drain();

    for (int b = 0; b < 3; b++) begin
      bp_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) ra[i] = $urandom;
      send_block(ra, 1'($urandom_range(0, 1)), 1'b0);
      wait_drain();
    end
    bp_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
